// File: rtl/matrix_col_driver.sv
// matrix_col_driver
// Column-data driver for the 8x8 LED dot matrix, the data-side partner of the
// row scanner. Holds a double-buffered frame (front/back banks). Control logic
// writes rows into the back bank. The front bank drives led_col for the row
// currently being scanned. Banks swap only at a frame boundary, so a
// half-written frame is never shown.
//
// Ports:
//   clk        system clock (shared with the row scanner)
//   rst        asynchronous, active-high reset
//   on_st      display enable, nonzero = on (same signal as the row scanner)
//   wr_en      back-bank write strobe
//   wr_row     row index for the write
//   wr_data    column pattern for the write, bit n = column n, 1 = LED on
//   swap_req   single-cycle request to swap banks at the next frame boundary
//   led_col    registered column drive for the current row, active-high
//   swap_pend  a swap is requested and not yet performed
//   swap_ack   high on the cycle whose clock edge performs the swap
//   frame_sync one-cycle pulse while led_col presents row 0
//
// Build option:
//   MATRIX_AUTOCLEAR_EN  when defined, the new back bank (the old front) is
//                        cleared on the cycle after swap_ack; a write in that
//                        cycle still lands in its own row.
//
// Swap FSM:
//   state | meaning
//   IDLE  | no swap outstanding
//   PEND  | swap requested, waiting for scan_cnt == 7

module matrix_col_driver #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      on_st,
    input  logic            wr_en,
    input  logic [2:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap_req,
    output logic [COLS-1:0] led_col,
    output logic            swap_pend,
    output logic            swap_ack,
    output logic            frame_sync
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      scan_cnt;
    logic            front_sel;
    logic [COLS-1:0] bank [2][ROWS];
    logic            display_on;
    logic            at_boundary;

    assign display_on  = |on_st;
    assign at_boundary = (scan_cnt == 3'd7);

    // Same reset/increment behaviour as the row scanner's counter, so the
    // two stay aligned without any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= 3'd0;
        end else begin
            scan_cnt <= scan_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request seen on the boundary cycle while already pending is a fresh
    // request for the following frame; otherwise extra requests are absorbed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (swap_req && !at_boundary) state_nxt = PEND;
            PEND: if (at_boundary) state_nxt = swap_req ? PEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        swap_pend = (state == PEND);
        swap_ack  = at_boundary && ((state == PEND) || swap_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel <= 1'b0;
        end else if (swap_ack) begin
            front_sel <= ~front_sel;
        end
    end

    // Row 0 loads on the edge after the swap, so it already sees the new front.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_col    <= '0;
            frame_sync <= 1'b0;
        end else begin
            led_col    <= display_on ? bank[front_sel][scan_cnt] : '0;
            frame_sync <= display_on && (scan_cnt == 3'd0);
        end
    end

`ifdef MATRIX_AUTOCLEAR_EN
    logic clr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= swap_ack;
        end
    end
`endif

    // Writes use the pre-edge front_sel, so a write on the swap edge lands in
    // the bank that is about to become the front.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
        end else begin
`ifdef MATRIX_AUTOCLEAR_EN
            if (clr_q) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[~front_sel][r] <= '0;
                end
            end
`endif
            // Placed after the clear so the written row wins.
            if (wr_en) begin
                bank[~front_sel][wr_row] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_col_driver.sv
module tb_matrix_col_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] on_st;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic [7:0] led_col;
    logic       swap_pend;
    logic       swap_ack;
    logic       frame_sync;

    always #5 clk = ~clk;

    matrix_col_driver #(.ROWS(8), .COLS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .on_st      (on_st),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .led_col    (led_col),
        .swap_pend  (swap_pend),
        .swap_ack   (swap_ack),
        .frame_sync (frame_sync)
    );

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;

    // reference model: frame position, which bank is shown, outstanding swap
    logic [7:0] m_bank [2][8];
    logic       m_front;
    logic       m_pend;
    logic       m_clr;
    logic [2:0] m_cnt;

    // last sampled DUT values
    logic       s_pend, s_ack, s_fs;
    logic [7:0] s_led;

    typedef struct {
        logic [1:0] on;
        logic       wen;
        logic [2:0] row;
        logic [7:0] data;
        logic       req;
        logic [7:0] exp_led;
        logic       exp_fs;
        logic       exp_pend;
        logic       exp_ack;
    } vec_t;

    vec_t vecs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                m_bank[b][r] = 8'h00;
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_clr   = 1'b0;
        m_cnt   = 3'd0;
    endtask

    // One clock cycle: drive at negedge, check combinational swap outputs,
    // advance the model, then check registered outputs after the edge.
    task automatic cycle(input logic [1:0] on, input logic wen, input logic [2:0] row,
                         input logic [7:0] data, input logic req);
        logic       e_ack;
        logic [7:0] e_led;
        logic       e_fs;
        @(negedge clk);
        on_st = on; wr_en = wen; wr_row = row; wr_data = data; swap_req = req;
        #1;
        e_ack  = (m_cnt == 3'd7) && (m_pend || req);
        s_pend = swap_pend;
        s_ack  = swap_ack;
        chk("swap_pend", 32'(s_pend), 32'(m_pend));
        chk("swap_ack", 32'(s_ack), 32'(e_ack));
        if (s_ack) ack_seen++;
        e_led = (on != 2'b00) ? m_bank[m_front][m_cnt] : 8'h00;
        e_fs  = (m_cnt == 3'd0) && (on != 2'b00);
`ifdef MATRIX_AUTOCLEAR_EN
        if (m_clr)
            for (int r = 0; r < 8; r++) m_bank[~m_front][r] = 8'h00;
`endif
        if (wen) m_bank[~m_front][row] = data;
        m_clr = e_ack;
        if (e_ack) m_front = ~m_front;
        if (m_cnt == 3'd7) m_pend = m_pend && req;
        else               m_pend = m_pend || req;
        m_cnt = m_cnt + 3'd1;
        @(posedge clk);
        #1;
        s_led = led_col;
        s_fs  = frame_sync;
        chk("led_col", 32'(s_led), 32'(e_led));
        chk("frame_sync", 32'(s_fs), 32'(e_fs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;

        // swap at cnt 3 after writing rows 0..7, then a direct swap at cnt 7
        // with a row-0 write of AA on the ack cycle
        for (int k = 0; k < 32; k++) begin
            vecs[k].on   = 2'b01;
            vecs[k].wen  = (k < 8) || (k == 23);
            vecs[k].row  = (k < 8) ? 3'(k) : 3'd0;
            vecs[k].data = (k < 8) ? 8'(1 << k) : ((k == 23) ? 8'hAA : 8'h00);
            vecs[k].req  = (k == 3) || (k == 23);
            if (k < 8)       vecs[k].exp_led = 8'h00;
            else if (k < 24) vecs[k].exp_led = 8'(1 << (k % 8));
            else if (k == 24) vecs[k].exp_led = 8'hAA;
            else             vecs[k].exp_led = 8'h00;
            vecs[k].exp_fs   = (k % 8 == 0);
            vecs[k].exp_pend = (k >= 4) && (k <= 7);
            vecs[k].exp_ack  = (k == 7) || (k == 23);
        end

        rst = 1'b1; on_st = 2'b00; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
        model_reset();
        #2;
        chk("rst_led", 32'(led_col), 32'h0);
        chk("rst_fs", 32'(frame_sync), 32'h0);
        chk("rst_pend", 32'(swap_pend), 32'h0);
        chk("rst_ack", 32'(swap_ack), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int k = 0; k < 32; k++) begin
            cycle(vecs[k].on, vecs[k].wen, vecs[k].row, vecs[k].data, vecs[k].req);
            chk($sformatf("tbl%0d_led", k), 32'(s_led), 32'(vecs[k].exp_led));
            chk($sformatf("tbl%0d_fs", k), 32'(s_fs), 32'(vecs[k].exp_fs));
            chk($sformatf("tbl%0d_pend", k), 32'(s_pend), 32'(vecs[k].exp_pend));
            chk($sformatf("tbl%0d_ack", k), 32'(s_ack), 32'(vecs[k].exp_ack));
        end

        // three requests in one frame -> exactly one swap
        a0 = ack_seen;
        for (int c = 0; c < 8; c++)
            cycle(2'b01, 1'b1, 3'(c), 8'h3C + 8'(c), (c == 1) || (c == 3) || (c == 5));
        chk("three_req_one_ack", 32'(ack_seen - a0), 32'd1);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("three_req_row0", 32'(s_led), 32'h3C);
        a0 = ack_seen;
        for (int c = 0; c < 15; c++) cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("no_extra_ack", 32'(ack_seen - a0), 32'd0);

        // display blanking mid-frame
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b00, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("blank_led", 32'(s_led), 32'h0);
        cycle(2'b00, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b00, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("unblank_row5", 32'(s_led), 32'h41);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b00, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("blank_no_sync", 32'(s_fs), 32'h0);
        for (int c = 1; c < 8; c++) cycle(2'b10, 1'b0, 3'd0, 8'h00, 1'b0);

        // reset while a swap is pending
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b1);
        cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("pend_before_rst", 32'(s_pend), 32'h1);
        @(negedge clk);
        swap_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_pend", 32'(swap_pend), 32'h0);
        chk("midrst_led", 32'(led_col), 32'h0);
        chk("midrst_ack", 32'(swap_ack), 32'h0);
        chk("midrst_fs", 32'(frame_sync), 32'h0);
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        a0 = ack_seen;
        for (int c = 0; c < 16; c++) cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("no_ack_after_rst", 32'(ack_seen - a0), 32'd0);

        // direct swaps at cnt 7, then a swap with no writes
        for (int c = 0; c < 8; c++) begin
            cycle(2'b01, 1'b1, 3'(c), 8'hFF, c == 7);
            if (c == 7) begin
                chk("direct_pend", 32'(s_pend), 32'h0);
                chk("direct_ack", 32'(s_ack), 32'h1);
            end
        end
        for (int c = 0; c < 8; c++) begin
            cycle(2'b01, 1'b1, 3'(c), 8'h55, c == 7);
            if (c == 0) chk("direct_row0", 32'(s_led), 32'hFF);
        end
        for (int c = 0; c < 8; c++) begin
            cycle(2'b01, 1'b0, 3'd0, 8'h00, c == 7);
            if (c == 0) chk("second_row0", 32'(s_led), 32'h55);
        end
        for (int c = 0; c < 8; c++) begin
            cycle(2'b01, 1'b0, 3'd0, 8'h00, 1'b0);
`ifdef MATRIX_AUTOCLEAR_EN
            if (c == 3) chk("autoclear_row3", 32'(s_led), 32'h00);
`else
            if (c == 3) chk("keep_row3", 32'(s_led), 32'hFF);
`endif
        end

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [1:0] r_on;
            r_on = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            cycle(r_on, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
